// File: rtl/snapshot_capture_ctrl.sv
// Snapshot capture sequencer: arm, wait for trigger, fill the BRAM once.
// Reports done/armed/capturing and the word count through status_out.
module snapshot_capture_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              user_clk,
    input  logic              user_rst_n,
    input  logic [31:0]       ctrl_in,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              trig,
    input  logic              stop,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_data,
    output logic              bram_we,
    output logic [31:0]       status_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

    state_t          state;
    state_t          state_nxt;
    logic [ADDR_W:0] count;
    logic [ADDR_W:0] count_nxt;
    logic            we_nxt;
    logic            ctrl0_q;
    logic            arm_block;
    logic            arm_edge;
    logic            trig_hit;
    logic [31:0]     status_nxt;
    logic            unused_ctrl;

    // Arm level held across reset is blocked until software drops it.
    assign arm_edge    = ctrl_in[0] & ~ctrl0_q & ~arm_block;
    assign trig_hit    = trig | ctrl_in[1];
    assign unused_ctrl = ^ctrl_in[31:2];

    // Next-state, next word count and write decision for this cycle.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        we_nxt    = 1'b0;
        unique case (state)
            IDLE: begin
                if (arm_edge) begin
                    state_nxt = ARMED;
                    count_nxt = '0;
                end
            end
            ARMED: begin
                if (arm_edge) begin
                    count_nxt = '0;
                end else if (trig_hit) begin
                    state_nxt = CAPTURE;
                    if (din_valid) begin
                        we_nxt    = 1'b1;
                        count_nxt = count + 1'b1;
                    end
                end
            end
            CAPTURE: begin
                if (arm_edge) begin
                    state_nxt = ARMED;
                    count_nxt = '0;
                end else begin
                    if (din_valid) begin
                        we_nxt    = 1'b1;
                        count_nxt = count + 1'b1;
                    end
                    if (count_nxt == FULL || stop) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (arm_edge) begin
                    state_nxt = ARMED;
                    count_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
    end

    // Status word built from next-state values so it lines up with bram_we.
    always_comb begin
        status_nxt             = '0;
        status_nxt[ADDR_W:0]   = count_nxt;
        status_nxt[31]         = (state_nxt == DONE);
        status_nxt[30]         = (state_nxt == ARMED);
        status_nxt[29]         = (state_nxt == CAPTURE);
    end

    // State, count, edge detect, registered write port and status.
    always_ff @(posedge user_clk) begin
        if (!user_rst_n) begin
            state      <= IDLE;
            count      <= '0;
            ctrl0_q    <= 1'b0;
            arm_block  <= ctrl_in[0];
            bram_we    <= 1'b0;
            bram_addr  <= '0;
            bram_data  <= '0;
            status_out <= '0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            ctrl0_q    <= ctrl_in[0];
            if (!ctrl_in[0]) begin
                arm_block <= 1'b0;
            end
            bram_we    <= we_nxt;
            if (we_nxt) begin
                bram_addr <= count[ADDR_W-1:0];
                bram_data <= din;
            end
            status_out <= status_nxt;
        end
    end

endmodule

// File: tb/tb_snapshot_capture_ctrl.sv
// Directed bench for snapshot_capture_ctrl with ADDR_W=4.
// Expected writes are queued by the driver and checked by a monitor.
module tb_snapshot_capture_ctrl;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   ctrl;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          trig;
    logic          stop;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_data;
    logic          bram_we;
    logic [31:0]   status_out;

    int checks = 0;
    int passes = 0;

    logic [31:0] qa[$];
    logic [31:0] qd[$];

    snapshot_capture_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .user_clk   (clk),
        .user_rst_n (rst_n),
        .ctrl_in    (ctrl),
        .din        (din),
        .din_valid  (din_valid),
        .trig       (trig),
        .stop       (stop),
        .bram_addr  (bram_addr),
        .bram_data  (bram_data),
        .bram_we    (bram_we),
        .status_out (status_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int a, input logic [31:0] d);
        qa.push_back(32'(a));
        qd.push_back(d);
    endtask

    // Monitor: every presented write must match the next queued one.
    always @(negedge clk) begin
        if (bram_we === 1'b1) begin
            if (qa.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%08h, none expected",
                         bram_addr, bram_data);
            end else begin
                check("wr_addr", 32'(bram_addr), qa.pop_front());
                check("wr_data", bram_data, qd.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0; ctrl = 0; din = 0; din_valid = 0; trig = 0; stop = 0;
        step(); step();
        check("rst_status", status_out, 32'h0);
        check("rst_we", {31'b0, bram_we}, 32'h0);
        check("rst_addr", 32'(bram_addr), 32'h0);
        rst_n = 1'b1;
        step();

        // Test 1: full buffer with continuous valid data
        ctrl = 32'h1;
        step();
        check("t1_armed", status_out, 32'h4000_0000);
        trig = 1; din_valid = 1;
        for (int i = 0; i < 16; i++) begin
            din = 32'(i);
            push(i, 32'(i));
            step();
            trig = 0;
            if (i == 0) check("t1_first", status_out, 32'h2000_0001);
        end
        check("t1_done", status_out, 32'h8000_0010);
        din = 32'd16;
        step();
        check("t1_we_off", {31'b0, bram_we}, 32'h0);
        check("t1_hold", status_out, 32'h8000_0010);
        din_valid = 0;

        // Test 2: arm + immediate trigger, alternating valid
        ctrl = 32'h0;
        step();
        ctrl = 32'h3;
        step();
        check("t2_armed", status_out, 32'h4000_0000);
        for (int k = 0; k < 31; k++) begin
            din_valid = (k % 2 == 0);
            din = 32'h100 + 32'(k);
            if (k % 2 == 0) push(k / 2, 32'h100 + 32'(k));
            step();
            if (k == 0) check("t2_first", status_out, 32'h2000_0001);
            if (k == 29) check("t2_mid", status_out, 32'h2000_000F);
        end
        check("t2_done", status_out, 32'h8000_0010);
        ctrl = 32'h0; din_valid = 0;
        step();

        // Test 3: stop with the sixth sample is inclusive
        ctrl = 32'h1;
        step();
        check("t3_armed", status_out, 32'h4000_0000);
        trig = 1; din_valid = 1;
        for (int i = 0; i < 6; i++) begin
            din = 32'h200 + 32'(i);
            stop = (i == 5);
            push(i, 32'h200 + 32'(i));
            step();
            trig = 0;
        end
        check("t3_done", status_out, 32'h8000_0006);
        stop = 0; din_valid = 0;
        step();
        check("t3_we_off", {31'b0, bram_we}, 32'h0);
        check("t3_hold", status_out, 32'h8000_0006);

        // Test 4: re-arm mid-capture at count 7
        ctrl = 32'h0;
        step();
        ctrl = 32'h1;
        step();
        ctrl = 32'h0;
        trig = 1; din_valid = 1;
        for (int i = 0; i < 7; i++) begin
            din = 32'h280 + 32'(i);
            push(i, 32'h280 + 32'(i));
            step();
            trig = 0;
        end
        check("t4_cnt7", status_out, 32'h2000_0007);
        ctrl = 32'h1; din = 32'hDEAD;
        step();
        check("t4_rearm", status_out, 32'h4000_0000);
        check("t4_no_we", {31'b0, bram_we}, 32'h0);
        trig = 1; din = 32'h300;
        push(0, 32'h300);
        step();
        trig = 0;
        check("t4_restart", status_out, 32'h2000_0001);

        // Test 5: reset at count 9, arm held high through reset
        for (int i = 1; i < 9; i++) begin
            din = 32'h300 + 32'(i);
            push(i, 32'h300 + 32'(i));
            step();
        end
        check("t5_cnt9", status_out, 32'h2000_0009);
        rst_n = 0; din = 32'hBEEF;
        step();
        check("t5_rst_status", status_out, 32'h0);
        check("t5_rst_we", {31'b0, bram_we}, 32'h0);
        rst_n = 1; din_valid = 0;
        step(); step();
        check("t5_no_rearm", status_out, 32'h0);
        ctrl = 32'h0;
        step();
        ctrl = 32'h1;
        step();
        check("t5_armed", status_out, 32'h4000_0000);

        // Test 6: armed without trigger ignores valid data
        din_valid = 1;
        for (int i = 0; i < 20; i++) begin
            din = 32'h400 + 32'(i);
            step();
            check("t6_wait", status_out, 32'h4000_0000);
        end
        din_valid = 0;
        step(); step();
        check("queue_empty", 32'(qa.size()), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
